// File: rtl/dummy_sched_pkg.sv
// Shared types and widths for the dummy scan scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dummy_sched_pkg;

    localparam int PERIOD_W = 16;
    localparam int CNT_W    = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TRIG = 3'd1,
        WAIT = 3'd2,
        COOL = 3'd3,
        READ = 3'd4
    } sched_state_t;

endpackage

// File: rtl/dummy_period_timer.sv
// Periodic dummy-scan timer: prescaler, period counter and overrun detection.
// Latency: tick_expire is decoded from registered counters in the cycle the period wraps.
// Backpressure: none; the timer free-runs while enabled and reports overrun_evt if the previous expiry is still pending.
module dummy_period_timer
    import dummy_sched_pkg::*;
#(
    parameter int PRESCALE = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sched_enable,
    input  logic [PERIOD_W-1:0] dummy_period,
    input  logic                per_pend,
    output logic                tick_expire,
    output logic                overrun_evt
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PERIOD_W-1:0] per_cnt;
    logic [PERIOD_W:0]   per_next;
    logic                run;
    logic                tick;

    // A zero period disables the source just like sched_enable=0.
    assign run      = sched_enable && (dummy_period != '0);
    assign tick     = run && (pre_cnt == PRE_W'(PRESCALE - 1));
    // Compare with >= so a period shortened below the current count still expires.
    assign per_next = {1'b0, per_cnt} + (PERIOD_W + 1)'(1);
    assign tick_expire = tick && (per_next >= {1'b0, dummy_period});
    assign overrun_evt = tick_expire && per_pend;

    // Prescaler and period counter; both held at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            pre_cnt <= '0;
            per_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            per_cnt <= tick_expire ? '0 : per_cnt + PERIOD_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/dummy_scan_scheduler.sv
// Arbitrates panel row-drive time between dummy scans (timer/manual) and readout frames.
// Latency: manual_req in cycle N -> dummy_trigger in cycle N+2; readout_grant one cycle after the IDLE decision.
// Backpressure: readout wins until MAX_DEFER grants pass with a dummy scan pending; requests during a scan are latched.
module dummy_scan_scheduler
    import dummy_sched_pkg::*;
#(
    parameter int PRESCALE  = 1000,
    parameter int GUARD     = 8,
    parameter int MAX_DEFER = 4,
    parameter int TIMEOUT   = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sched_enable,
    input  logic [PERIOD_W-1:0] dummy_period,
    input  logic                manual_req,
    input  logic                err_clear,
    input  logic                readout_req,
    input  logic                readout_done,
    input  logic                dummy_complete,
    output logic                dummy_trigger,
    output logic                readout_grant,
    output logic                dummy_busy,
    output logic [CNT_W-1:0]    scan_count,
    output logic                timeout_err,
    output logic                overrun
);

    localparam int DEF_W = $clog2(MAX_DEFER + 1);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;

    sched_state_t     state;
    logic             per_pend;
    logic             man_pend;
    logic             dummy_pend;
    logic [DEF_W-1:0] defer_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GRD_W-1:0] cool_cnt;
    logic             tick_expire;
    logic             overrun_evt;
    logic             defer_full;
    logic             timeout_evt;

    dummy_period_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .sched_enable (sched_enable),
        .dummy_period (dummy_period),
        .per_pend     (per_pend),
        .tick_expire  (tick_expire),
        .overrun_evt  (overrun_evt)
    );

    assign dummy_pend = per_pend | man_pend;
    assign defer_full = (defer_cnt == DEF_W'(MAX_DEFER));
    // WAIT is entered with tmo_cnt=0; the error lands when the count becomes
    // TIMEOUT-1, i.e. exactly TIMEOUT cycles after the trigger pulse.
    assign timeout_evt = (state == WAIT) && !dummy_complete &&
                         (tmo_cnt == TMO_W'(TIMEOUT - 2));

    // Pending flags: a new request in the TRIG cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_pend <= 1'b0;
            man_pend <= 1'b0;
        end else begin
            per_pend <= tick_expire | (per_pend & (state != TRIG));
            man_pend <= manual_req  | (man_pend & (state != TRIG));
        end
    end

    // Sticky error flags; a set in the same cycle as err_clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            timeout_err <= timeout_evt | (timeout_err & !err_clear);
            overrun     <= overrun_evt | (overrun & !err_clear);
        end
    end

    // Scheduler FSM with registered trigger, grant, busy and scan counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            defer_cnt     <= '0;
            tmo_cnt       <= '0;
            cool_cnt      <= '0;
            dummy_trigger <= 1'b0;
            readout_grant <= 1'b0;
            dummy_busy    <= 1'b0;
            scan_count    <= '0;
        end else begin
            dummy_trigger <= 1'b0;
            case (state)
                IDLE: begin
                    if (readout_req && !(dummy_pend && defer_full)) begin
                        state         <= READ;
                        readout_grant <= 1'b1;
                        if (dummy_pend) begin
                            defer_cnt <= defer_cnt + DEF_W'(1);
                        end
                    end else if (dummy_pend) begin
                        state         <= TRIG;
                        dummy_trigger <= 1'b1;
                        dummy_busy    <= 1'b1;
                    end
                end
                TRIG: begin
                    // One scan services both sources, so the defer budget restarts.
                    state     <= WAIT;
                    tmo_cnt   <= '0;
                    defer_cnt <= '0;
                end
                WAIT: begin
                    if (dummy_complete) begin
                        state      <= COOL;
                        cool_cnt   <= '0;
                        scan_count <= scan_count + CNT_W'(1);
                    end else if (timeout_evt) begin
                        state      <= IDLE;
                        dummy_busy <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                COOL: begin
                    if (cool_cnt == GRD_W'(GUARD - 1)) begin
                        state      <= IDLE;
                        dummy_busy <= 1'b0;
                    end else begin
                        cool_cnt <= cool_cnt + GRD_W'(1);
                    end
                end
                READ: begin
                    // Only readout_done ends a frame; dropping readout_req does not.
                    if (readout_done) begin
                        state         <= IDLE;
                        readout_grant <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    readout_grant <= 1'b0;
                    dummy_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dummy_scan_scheduler.sv
// Directed bench for dummy_scan_scheduler with hand-computed expectations.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: every wait on the design is bounded by a cycle budget.
module tb_dummy_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        sched_enable;
    logic [15:0] dummy_period;
    logic        manual_req;
    logic        err_clear;
    logic        readout_req;
    logic        readout_done;
    logic        dummy_complete;
    logic        dummy_trigger;
    logic        readout_grant;
    logic        dummy_busy;
    logic [15:0] scan_count;
    logic        timeout_err;
    logic        overrun;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    dummy_scan_scheduler #(
        .PRESCALE  (10),
        .GUARD     (8),
        .MAX_DEFER (4),
        .TIMEOUT   (200)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sched_enable   (sched_enable),
        .dummy_period   (dummy_period),
        .manual_req     (manual_req),
        .err_clear      (err_clear),
        .readout_req    (readout_req),
        .readout_done   (readout_done),
        .dummy_complete (dummy_complete),
        .dummy_trigger  (dummy_trigger),
        .readout_grant  (readout_grant),
        .dummy_busy     (dummy_busy),
        .scan_count     (scan_count),
        .timeout_err    (timeout_err),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic nc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_trig(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (dummy_trigger) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nc(2);
        rst = 1'b0;
        nc(1);
    endtask

    initial begin
        bit seen;
        int t1;
        int t2;
        int grants;
        int trigs;
        bit prev_grant;

        rst = 1'b1; sched_enable = 1'b0; dummy_period = 16'd0; manual_req = 1'b0;
        err_clear = 1'b0; readout_req = 1'b0; readout_done = 1'b0; dummy_complete = 1'b0;
        nc(3);
        check("rst_trigger", dummy_trigger, 0);
        check("rst_grant",   readout_grant, 0);
        check("rst_busy",    dummy_busy, 0);
        check("rst_count",   scan_count, 0);
        check("rst_tmo",     timeout_err, 0);
        check("rst_ovr",     overrun, 0);
        rst = 1'b0;
        nc(2);

        // Manual request: trigger two cycles later, one cycle wide, guard after completion.
        dummy_period = 16'd5;
        manual_req = 1'b1;
        nc(1); manual_req = 1'b0;
        check("man_trig_n1", dummy_trigger, 0);
        nc(1);
        check("man_trig_n2", dummy_trigger, 1);
        check("man_busy_trig", dummy_busy, 1);
        nc(1);
        check("man_trig_n3", dummy_trigger, 0);
        dummy_complete = 1'b1;
        nc(1); dummy_complete = 1'b0;
        check("man_count", scan_count, 1);
        check("man_busy_cool", dummy_busy, 1);
        nc(7);
        check("man_busy_guard_end", dummy_busy, 1);
        nc(1);
        check("man_busy_low", dummy_busy, 0);

        // Timeout: engine never completes; error 200 cycles after trigger, set beats clear.
        manual_req = 1'b1;
        nc(1); manual_req = 1'b0;
        nc(1);
        check("tmo_trig", dummy_trigger, 1);
        nc(198);
        nc(1);
        check("tmo_err_early", timeout_err, 0);
        check("tmo_busy_early", dummy_busy, 1);
        err_clear = 1'b1;
        nc(1);
        check("tmo_err_set_wins", timeout_err, 1);
        check("tmo_busy_idle", dummy_busy, 0);
        check("tmo_count_same", scan_count, 1);
        nc(1); err_clear = 1'b0;
        check("tmo_err_cleared", timeout_err, 0);

        // Periodic: PRESCALE=10, period=5 -> 50-cycle spacing; hold engine to force overrun.
        do_reset();
        sched_enable = 1'b1;
        wait_trig(120, seen);
        check("per_first_seen", seen, 1);
        t1 = cyc;
        nc(1); dummy_complete = 1'b1;
        nc(1); dummy_complete = 1'b0;
        wait_trig(120, seen);
        check("per_second_seen", seen, 1);
        t2 = cyc;
        check("per_interval", t2 - t1, 50);
        nc(98);
        check("per_ovr_early", overrun, 0);
        nc(1);
        check("per_ovr_set", overrun, 1);
        check("per_busy_held", dummy_busy, 1);
        sched_enable = 1'b0;
        dummy_complete = 1'b1;
        nc(1); dummy_complete = 1'b0;
        err_clear = 1'b1;
        nc(1); err_clear = 1'b0;
        check("per_ovr_cleared", overrun, 0);
        check("per_count", scan_count, 2);

        // Simultaneous manual request and timer expiry: one trigger services both.
        do_reset();
        sched_enable = 1'b1;
        nc(49);
        manual_req = 1'b1;
        nc(1); manual_req = 1'b0; sched_enable = 1'b0;
        check("sim_not_yet", dummy_trigger, 0);
        check("sim_busy_idle", dummy_busy, 0);
        nc(1);
        check("sim_trig", dummy_trigger, 1);
        nc(1); dummy_complete = 1'b1;
        nc(1); dummy_complete = 1'b0;
        check("sim_count", scan_count, 1);
        trigs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dummy_trigger) trigs++;
        end
        check("sim_single_trigger", trigs, 0);
        check("sim_busy_end", dummy_busy, 0);

        // Arbitration: readout held with a dummy pending -> 4 grants, trigger, then readout resumes.
        do_reset();
        readout_req = 1'b1;
        nc(1);
        check("arb_first_grant", readout_grant, 1);
        manual_req = 1'b1; readout_done = 1'b1;
        grants = 0; prev_grant = 1'b0; seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            manual_req = 1'b0;
            if (dummy_trigger) begin
                seen = 1'b1;
                break;
            end
            if (readout_grant && !prev_grant) grants++;
            prev_grant = readout_grant;
            readout_done = readout_grant;
        end
        readout_done = 1'b0;
        check("arb_trig_seen", seen, 1);
        check("arb_grants", grants, 4);
        check("arb_grant_low", readout_grant, 0);
        nc(1); dummy_complete = 1'b1;
        nc(1); dummy_complete = 1'b0;
        check("arb_count", scan_count, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (readout_grant) begin
                seen = 1'b1;
                break;
            end
        end
        check("arb_resume", seen, 1);
        readout_req = 1'b0;
        nc(3);
        check("arb_req_drop_holds", readout_grant, 1);
        readout_done = 1'b1;
        nc(1); readout_done = 1'b0;
        check("arb_done_release", readout_grant, 0);

        // Reset during WAIT aborts; a late completion is ignored.
        manual_req = 1'b1;
        nc(1); manual_req = 1'b0;
        nc(1);
        check("rmid_trig", dummy_trigger, 1);
        nc(1);
        rst = 1'b1;
        nc(1); rst = 1'b0;
        check("rmid_busy", dummy_busy, 0);
        check("rmid_count", scan_count, 0);
        check("rmid_grant", readout_grant, 0);
        check("rmid_trigger", dummy_trigger, 0);
        dummy_complete = 1'b1;
        nc(1); dummy_complete = 1'b0;
        trigs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dummy_trigger) trigs++;
        end
        check("rmid_late_complete_count", scan_count, 0);
        check("rmid_no_retrigger", trigs, 0);
        check("rmid_busy_end", dummy_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
